// File: rtl/fetch_unit_if.sv
// Bus between the controller side and the fetch unit: controller strobes,
// memory read data, and the address/IR/PC/status outputs of the fetch unit.
interface fetch_unit_if #(
    parameter int AWIDTH   = 5,
    parameter int OPWIDTH  = 3,
    parameter int CNTWIDTH = 16
);
    localparam int DWIDTH = OPWIDTH + AWIDTH;

    logic                ld_ir;
    logic                inc_pc;
    logic                ld_pc;
    logic                sel;
    logic                halt;
    logic [DWIDTH-1:0]   data_in;
    logic [AWIDTH-1:0]   addr;
    logic [OPWIDTH-1:0]  opcode;
    logic [AWIDTH-1:0]   ir_addr;
    logic [AWIDTH-1:0]   pc;
    logic                halted;
    logic                pc_wrap;
    logic [CNTWIDTH-1:0] instr_count;

    modport master (
        output ld_ir, inc_pc, ld_pc, sel, halt, data_in,
        input  addr, opcode, ir_addr, pc, halted, pc_wrap, instr_count
    );

    modport slave (
        input  ld_ir, inc_pc, ld_pc, sel, halt, data_in,
        output addr, opcode, ir_addr, pc, halted, pc_wrap, instr_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-side datapath: PC, IR, memory address mux, sticky halt and a
// saturating count of fetched instructions.
module fetch_unit #(
    parameter int AWIDTH   = 5,
    parameter int OPWIDTH  = 3,
    parameter int CNTWIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.slave   bus
);
    localparam int DWIDTH = OPWIDTH + AWIDTH;

    logic [AWIDTH-1:0]   pc_q;
    logic [DWIDTH-1:0]   ir_q;
    logic                halted_q;
    logic                pc_wrap_q;
    logic                ld_ir_d;
    logic [CNTWIDTH-1:0] count_q;
    logic [AWIDTH-1:0]   ir_addr_w;
    logic                active;

    assign ir_addr_w = ir_q[AWIDTH-1:0];
    // A halt strobe freezes the datapath on the very edge it is seen.
    assign active    = !halted_q && !bus.halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            pc_wrap_q <= 1'b0;
            ld_ir_d   <= 1'b0;
            count_q   <= '0;
        end else begin
            ld_ir_d   <= bus.ld_ir;
            pc_wrap_q <= 1'b0;
            if (bus.halt) begin
                halted_q <= 1'b1;
            end
            if (active) begin
                if (bus.ld_ir) begin
                    ir_q <= bus.data_in;
                end
                if (bus.ld_pc) begin
                    pc_q <= ir_addr_w;
                end else if (bus.inc_pc) begin
                    pc_q      <= pc_q + AWIDTH'(1);
                    pc_wrap_q <= (pc_q == '1);
                end
                // ld_ir is held for two cycles; only its rising edge counts.
                if (bus.ld_ir && !ld_ir_d && (count_q != '1)) begin
                    count_q <= count_q + CNTWIDTH'(1);
                end
            end
        end
    end

    assign bus.addr        = bus.sel ? pc_q : ir_addr_w;
    assign bus.opcode      = ir_q[DWIDTH-1:AWIDTH];
    assign bus.ir_addr     = ir_addr_w;
    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;
    assign bus.pc_wrap     = pc_wrap_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors push expected state,
// a monitor compares shortly after each rising edge.
module tb_fetch_unit;
    logic       clk;
    logic       reset;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       sel;
    logic       halt;
    logic [7:0] data_in;

    int cyc;
    int n_checks;
    int n_fail;

    typedef struct {
        int         cyc;
        logic [4:0] pc;
        logic [7:0] ir;
        logic       halted;
        logic       wrap;
        logic [15:0] cnt;
        logic [4:0] addr;
    } exp_t;

    exp_t exp_q[$];

    fetch_unit_if #(.AWIDTH(5), .OPWIDTH(3), .CNTWIDTH(16)) bus ();
    fetch_unit_if #(.AWIDTH(5), .OPWIDTH(3), .CNTWIDTH(4))  bus_s ();

    // Both instances see identical stimulus; the narrow one exercises saturation.
    assign bus.ld_ir     = ld_ir;
    assign bus.inc_pc    = inc_pc;
    assign bus.ld_pc     = ld_pc;
    assign bus.sel       = sel;
    assign bus.halt      = halt;
    assign bus.data_in   = data_in;
    assign bus_s.ld_ir   = ld_ir;
    assign bus_s.inc_pc  = inc_pc;
    assign bus_s.ld_pc   = ld_pc;
    assign bus_s.sel     = sel;
    assign bus_s.halt    = halt;
    assign bus_s.data_in = data_in;

    fetch_unit #(.AWIDTH(5), .OPWIDTH(3), .CNTWIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    fetch_unit #(.AWIDTH(5), .OPWIDTH(3), .CNTWIDTH(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic       li, input logic ip, input logic lp, input logic s, input logic h,
        input logic [7:0] d,
        input logic [4:0] e_pc, input logic [7:0] e_ir, input logic e_halted,
        input logic       e_wrap, input logic [15:0] e_cnt, input logic [4:0] e_addr
    );
        exp_t e;
        @(negedge clk);
        ld_ir   = li;
        inc_pc  = ip;
        ld_pc   = lp;
        sel     = s;
        halt    = h;
        data_in = d;
        e.cyc    = cyc + 1;
        e.pc     = e_pc;
        e.ir     = e_ir;
        e.halted = e_halted;
        e.wrap   = e_wrap;
        e.cnt    = e_cnt;
        e.addr   = e_addr;
        exp_q.push_back(e);
    endtask

    // Reset is raised between edges and checked before the next rising edge.
    task automatic asyncReset();
        exp_t e;
        @(negedge clk);
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        sel     = 1'b0;
        halt    = 1'b0;
        data_in = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        e.cyc    = cyc;
        e.pc     = 5'd0;
        e.ir     = 8'h00;
        e.halted = 1'b0;
        e.wrap   = 1'b0;
        e.cnt    = 16'd0;
        e.addr   = 5'd0;
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #3;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checkOutput("pc",          16'(bus.pc),          16'(e.pc));
            checkOutput("opcode",      16'(bus.opcode),      16'(e.ir[7:5]));
            checkOutput("ir_addr",     16'(bus.ir_addr),     16'(e.ir[4:0]));
            checkOutput("halted",      16'(bus.halted),      16'(e.halted));
            checkOutput("pc_wrap",     16'(bus.pc_wrap),     16'(e.wrap));
            checkOutput("instr_count", bus.instr_count,      e.cnt);
            checkOutput("addr",        16'(bus.addr),        16'(e.addr));
            checkOutput("count_sat",   16'(bus_s.instr_count), (e.cnt > 16'd15) ? 16'd15 : e.cnt);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        ld_ir    = 1'b0;
        inc_pc   = 1'b0;
        ld_pc    = 1'b0;
        sel      = 1'b0;
        halt     = 1'b0;
        data_in  = 8'h00;

        //            li ip lp s  h  data    pc     ir     hlt  wrp  cnt    addr
        applyStimulus(0, 0, 0, 0, 0, 8'h00, 5'd0,  8'h00, 0, 0, 16'd0, 5'd0);
        reset = 1'b0;

        // IR load held two cycles counts once
        applyStimulus(1, 0, 0, 1, 0, 8'hA7, 5'd0,  8'hA7, 0, 0, 16'd1, 5'd0);
        applyStimulus(1, 0, 0, 1, 0, 8'hA7, 5'd0,  8'hA7, 0, 0, 16'd1, 5'd0);
        applyStimulus(0, 0, 0, 0, 0, 8'h00, 5'd0,  8'hA7, 0, 0, 16'd1, 5'd7);

        // PC wrap from 31, then ld_pc of 0 does not pulse
        applyStimulus(1, 0, 0, 1, 0, 8'h1F, 5'd0,  8'h1F, 0, 0, 16'd2, 5'd0);
        applyStimulus(1, 0, 0, 1, 0, 8'h1F, 5'd0,  8'h1F, 0, 0, 16'd2, 5'd0);
        applyStimulus(0, 0, 1, 1, 0, 8'h00, 5'd31, 8'h1F, 0, 0, 16'd2, 5'd31);
        applyStimulus(0, 1, 0, 1, 0, 8'h00, 5'd0,  8'h1F, 0, 1, 16'd2, 5'd0);
        applyStimulus(0, 0, 0, 1, 0, 8'h00, 5'd0,  8'h1F, 0, 0, 16'd2, 5'd0);
        applyStimulus(1, 0, 0, 1, 0, 8'h00, 5'd0,  8'h00, 0, 0, 16'd3, 5'd0);
        applyStimulus(1, 0, 0, 1, 0, 8'h00, 5'd0,  8'h00, 0, 0, 16'd3, 5'd0);
        applyStimulus(0, 0, 1, 1, 0, 8'h00, 5'd0,  8'h00, 0, 0, 16'd3, 5'd0);

        // ld_pc wins over inc_pc; address mux both ways
        applyStimulus(1, 0, 0, 1, 0, 8'h6C, 5'd0,  8'h6C, 0, 0, 16'd4, 5'd0);
        applyStimulus(1, 0, 0, 1, 0, 8'h6C, 5'd0,  8'h6C, 0, 0, 16'd4, 5'd0);
        applyStimulus(0, 1, 1, 0, 0, 8'h00, 5'd12, 8'h6C, 0, 0, 16'd4, 5'd12);
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 5'd13, 8'h6C, 0, 0, 16'd4, 5'd12);
        applyStimulus(0, 0, 0, 1, 0, 8'h00, 5'd13, 8'h6C, 0, 0, 16'd4, 5'd13);

        // Halt beats inc_pc; everything frozen afterwards
        applyStimulus(1, 0, 0, 1, 0, 8'h84, 5'd13, 8'h84, 0, 0, 16'd5, 5'd13);
        applyStimulus(1, 0, 0, 1, 0, 8'h84, 5'd13, 8'h84, 0, 0, 16'd5, 5'd13);
        applyStimulus(0, 0, 1, 1, 0, 8'h00, 5'd4,  8'h84, 0, 0, 16'd5, 5'd4);
        applyStimulus(0, 1, 0, 1, 1, 8'h00, 5'd4,  8'h84, 1, 0, 16'd5, 5'd4);
        applyStimulus(1, 1, 1, 1, 0, 8'hFF, 5'd4,  8'h84, 1, 0, 16'd5, 5'd4);
        applyStimulus(0, 1, 0, 0, 0, 8'hFF, 5'd4,  8'h84, 1, 0, 16'd5, 5'd4);
        applyStimulus(0, 0, 1, 1, 0, 8'h00, 5'd4,  8'h84, 1, 0, 16'd5, 5'd4);
        applyStimulus(0, 0, 0, 1, 1, 8'h00, 5'd4,  8'h84, 1, 0, 16'd5, 5'd4);
        asyncReset();

        // Reach pc=9, halt, then reset between edges
        applyStimulus(1, 0, 0, 1, 0, 8'h29, 5'd0,  8'h29, 0, 0, 16'd1, 5'd0);
        applyStimulus(1, 0, 0, 1, 0, 8'h29, 5'd0,  8'h29, 0, 0, 16'd1, 5'd0);
        applyStimulus(0, 0, 1, 1, 0, 8'h00, 5'd9,  8'h29, 0, 0, 16'd1, 5'd9);
        applyStimulus(0, 0, 0, 1, 1, 8'h00, 5'd9,  8'h29, 1, 0, 16'd1, 5'd9);
        asyncReset();

        // 17 instructions: narrow counter saturates at 15, wide one reaches 17
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 8'(i), 5'd0, 8'(i), 0, 0, 16'(i), 5'd0);
            applyStimulus(0, 0, 0, 1, 0, 8'h00, 5'd0, 8'(i), 0, 0, 16'(i), 5'd0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
